// File: rtl/inst_rom_responder.sv
// Instruction-memory responder: word RAM behind the core fetch port, filled by a
// byte-serial little-endian loader. Fetches are blocked while the loader is active.
module inst_rom_responder #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h1c000000,
    parameter logic [31:0] NOP_INST  = 32'h03400000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_en_i,
    input  logic [31:0]       inst_addr_i,
    output logic [31:0]       inst_o,
    output logic              inst_err_o,
    output logic              busy_o,
    input  logic              load_start_i,
    input  logic              load_valid_i,
    input  logic [7:0]        load_byte_i,
    input  logic              load_last_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    output logic [ADDR_W:0]   load_words_o,
    output logic              load_ovf_o
);

    localparam int unsigned    Depth     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DepthCnt = {1'b1, {ADDR_W{1'b0}}};
    // One past the last valid byte address, kept 33 bits wide so the bound cannot wrap.
    localparam logic [32:0]    AddrLimit = {1'b0, BASE_ADDR} +
                                           {{(30 - ADDR_W){1'b0}}, DepthCnt, 2'b00};

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCommit,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       acc_q, acc_d;
    logic              last_q, last_d;
    logic              ovf_q, ovf_d;
    logic              ram_we;

    logic [31:0]       inst_q;
    logic              inst_err_q;

    logic [31:0]       mem [Depth];

    logic [ADDR_W-1:0] fetch_idx;
    logic              fetch_ok;

    assign fetch_idx = ADDR_W'((inst_addr_i - BASE_ADDR) >> 2);
    assign fetch_ok  = (inst_addr_i[1:0] == 2'b00) &&
                       (inst_addr_i >= BASE_ADDR) &&
                       ({1'b0, inst_addr_i} < AddrLimit);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lane_d  = lane_q;
        acc_d   = acc_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        ram_we  = 1'b0;
        case (state_q)
            StIdle: begin
                if (load_start_i) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                    lane_d  = 2'd0;
                    acc_d   = '0;
                    last_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            StLoad: begin
                if (load_valid_i) begin
                    acc_d[8*lane_q +: 8] = load_byte_i;
                    lane_d               = lane_q + 2'd1;
                    last_d               = load_last_i;
                    if (lane_q == 2'd3 || load_last_i) begin
                        state_d = StCommit;
                    end
                end
            end
            StCommit: begin
                // Words past the end are still consumed but dropped.
                if (ptr_q < DepthCnt) begin
                    ram_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
                lane_d  = 2'd0;
                acc_d   = '0;
                state_d = last_q ? StDone : StLoad;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            lane_q  <= 2'd0;
            acc_q   <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lane_q  <= lane_d;
            acc_q   <= acc_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ptr_q[ADDR_W-1:0]] <= acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inst_q     <= NOP_INST;
            inst_err_q <= 1'b0;
        end else if (state_q != StIdle) begin
            inst_q     <= NOP_INST;
            inst_err_q <= 1'b0;
        end else if (inst_en_i) begin
            if (fetch_ok) begin
                inst_q     <= mem[fetch_idx];
                inst_err_q <= 1'b0;
            end else begin
                inst_q     <= NOP_INST;
                inst_err_q <= 1'b1;
            end
        end
    end

    assign inst_o       = inst_q;
    assign inst_err_o   = inst_err_q;
    assign busy_o       = (state_q != StIdle);
    assign load_ready_o = (state_q == StLoad);
    assign load_done_o  = (state_q == StDone);
    assign load_words_o = ptr_q;
    assign load_ovf_o   = ovf_q;

endmodule

// File: tb/tb_inst_rom_responder.sv
// Directed bench: a default-size responder and a 4-word responder share all inputs,
// so the overflow case runs on the small one while the rest is checked on the large one.
module tb_inst_rom_responder;

    localparam logic [31:0] Nop = 32'h03400000;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic        load_start, load_valid, load_last;
    logic [7:0]  load_byte;

    logic [31:0] inst, s_inst;
    logic        inst_err, s_inst_err, busy, s_busy;
    logic        load_ready, s_load_ready, load_done, s_load_done;
    logic        load_ovf, s_load_ovf;
    logic [10:0] load_words;
    logic [2:0]  s_load_words;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    inst_rom_responder #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .inst_en_i(inst_en), .inst_addr_i(inst_addr),
        .inst_o(inst), .inst_err_o(inst_err), .busy_o(busy),
        .load_start_i(load_start), .load_valid_i(load_valid), .load_byte_i(load_byte),
        .load_last_i(load_last), .load_ready_o(load_ready), .load_done_o(load_done),
        .load_words_o(load_words), .load_ovf_o(load_ovf)
    );

    inst_rom_responder #(.ADDR_W(2)) dut_small (
        .clk(clk), .rst(rst), .inst_en_i(inst_en), .inst_addr_i(inst_addr),
        .inst_o(s_inst), .inst_err_o(s_inst_err), .busy_o(s_busy),
        .load_start_i(load_start), .load_valid_i(load_valid), .load_byte_i(load_byte),
        .load_last_i(load_last), .load_ready_o(s_load_ready), .load_done_o(s_load_done),
        .load_words_o(s_load_words), .load_ovf_o(s_load_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        while (!load_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready", {31'b0, load_ready}, 32'd1);
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        inst_en   = 1'b1;
        inst_addr = addr;
        tick();
        inst_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b0; inst_en = 1'b0; inst_addr = '0;
        load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_byte = '0;

        // Reset state
        tick(); tick();
        check("rst_inst", inst, Nop);
        check("rst_err", {31'b0, inst_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ready", {31'b0, load_ready}, 32'd0);
        check("rst_done", {31'b0, load_done}, 32'd0);
        check("rst_words", {21'b0, load_words}, 32'd0);
        check("rst_ovf", {31'b0, load_ovf}, 32'd0);
        check("rst_s_inst", s_inst, Nop);
        rst = 1'b1;
        tick();

        // Two-word load
        start_load();
        check("load_busy", {31'b0, busy}, 32'd1);
        send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'h78, 1'b0); send_byte(8'h56, 1'b0);
        send_byte(8'h34, 1'b0); send_byte(8'h12, 1'b1);
        check("commit_nodone", {31'b0, load_done}, 32'd0);
        tick();
        check("done_pulse", {31'b0, load_done}, 32'd1);
        tick();
        check("done_clear", {31'b0, load_done}, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("words2", {21'b0, load_words}, 32'd2);
        fetch(32'h1c000000);
        check("fetch0", inst, 32'h02000013);
        check("fetch0_err", {31'b0, inst_err}, 32'd0);
        fetch(32'h1c000004);
        check("fetch1", inst, 32'h12345678);
        tick();
        check("hold", inst, 32'h12345678);

        // Partial word zero-fills upper lanes
        start_load();
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b1);
        tick(); tick();
        check("words1", {21'b0, load_words}, 32'd1);
        fetch(32'h1c000000);
        check("partial", inst, 32'h0000BBAA);
        fetch(32'h1c000004);
        check("untouched", inst, 32'h12345678);

        // Invalid fetches
        fetch(32'h1c000002);
        check("misalign", inst, Nop);
        check("misalign_err", {31'b0, inst_err}, 32'd1);
        fetch(32'h1c000ffc);
        check("last_word_err", {31'b0, inst_err}, 32'd0);
        fetch(32'h1c001000);
        check("past_end", inst, Nop);
        check("past_end_err", {31'b0, inst_err}, 32'd1);
        fetch(32'h00000000);
        check("below_base_err", {31'b0, inst_err}, 32'd1);
        fetch(32'hfffffffc);
        check("top_err", {31'b0, inst_err}, 32'd1);

        // Fetch blocked during load, then reset mid-word
        start_load();
        fetch(32'h1c000004);
        check("blocked", inst, Nop);
        check("blocked_err", {31'b0, inst_err}, 32'd0);
        send_byte(8'h44, 1'b0); send_byte(8'h33, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'h11, 1'b0);
        send_byte(8'h99, 1'b0); send_byte(8'h88, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_words", {21'b0, load_words}, 32'd0);
        fetch(32'h1c000000);
        check("kept0", inst, 32'h11223344);
        fetch(32'h1c000004);
        check("kept1", inst, 32'h12345678);

        // Overflow on the 4-word instance
        start_load();
        for (int i = 0; i < 20; i++) begin
            send_byte(8'h10 + 8'(i), (i == 19));
        end
        tick(); tick();
        check("ovf_words", {29'b0, s_load_words}, 32'd4);
        check("ovf_flag", {31'b0, s_load_ovf}, 32'd1);
        check("no_ovf_big", {31'b0, load_ovf}, 32'd0);
        fetch(32'h1c000000);
        check("ovf_w0", s_inst, 32'h13121110);
        fetch(32'h1c00000c);
        check("ovf_w3", s_inst, 32'h1f1e1d1c);
        fetch(32'h1c000010);
        check("small_end_err", {31'b0, s_inst_err}, 32'd1);
        tick();
        check("ovf_sticky", {31'b0, s_load_ovf}, 32'd1);
        start_load();
        check("ovf_cleared", {31'b0, s_load_ovf}, 32'd0);
        send_byte(8'h5a, 1'b1);
        tick(); tick();
        check("reload_words", {29'b0, s_load_words}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
